// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the bit-counter width helper.
// Optional build macro: UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
`endif

  // Width of a counter that indexes n data bits (at least one bit wide).
  function automatic int bit_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: down-counter of CLK_FREQ/BAUD cycles, reloaded at each
// bit boundary; tick marks the last cycle of a bit period while run is high.
module uart_baud_gen #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Hold the counter at full period while idle so the first bit gets DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!run || (cnt_r == '0)) begin
      cnt_r <= RELOAD;
    end else begin
      cnt_r <= cnt_r - CW'(1);
    end
  end

  assign tick = run && (cnt_r == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, SIZE data bits LSB first, stop bit.
// Optional build macro: UART_TX_PARITY_EN inserts an even-parity bit after data.
module uart_tx
  import uart_pkg::*;
#(
  parameter int SIZE     = 8,
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 9600
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] word,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int BW = bit_cnt_width(SIZE);
  localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

  uart_state_e     state_r, state_next;
  logic            sync1_r, sync2_r, sync_prev_r;
  logic [2:0]      settle_r;
  logic            req_s, tick_s, run_s;
  logic            load_s, shift_en_s, done_next_s;
  logic [SIZE-1:0] shift_r;
  logic [BW-1:0]   bit_cnt_r;
  logic            tx_r, busy_r, done_r;
`ifdef UART_TX_PARITY_EN
  logic            par_r;
`endif

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run_s),
    .tick  (tick_s)
  );

  assign run_s = (state_r != IDLE);

  // Synchronize start and track how long since reset so a level held across
  // reset release is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      sync_prev_r <= 1'b0;
      settle_r    <= 3'b000;
    end else begin
      sync1_r     <= start;
      sync2_r     <= sync1_r;
      sync_prev_r <= sync2_r;
      settle_r    <= {settle_r[1:0], 1'b1};
    end
  end

  assign req_s = sync2_r & ~sync_prev_r & settle_r[2];

  // Next-state and datapath control decode.
  always_comb begin
    state_next  = state_r;
    load_s      = 1'b0;
    shift_en_s  = 1'b0;
    done_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_next = START;
          load_s     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_next = DATA;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            state_next = DATA;
          end
        end else begin
          state_next = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_s) begin
          state_next = STOP;
        end else begin
          state_next = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick_s) begin
          state_next  = IDLE;
          done_next_s = 1'b1;
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Shift register and data-bit counter; word is captured only on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
`ifdef UART_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else if (load_s) begin
      shift_r   <= word;
      bit_cnt_r <= '0;
`ifdef UART_TX_PARITY_EN
      par_r     <= ^word;
`endif
    end else if (shift_en_s) begin
      shift_r   <= shift_r >> 1;
      bit_cnt_r <= bit_cnt_r + BW'(1);
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Registered line and status outputs; done and the busy drop share one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next != IDLE);
      done_r <= done_next_s;
      case (state_r)
        START:   tx_r <= 1'b0;
        DATA:    tx_r <= shift_r[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  tx_r <= par_r;
`endif
        default: tx_r <= 1'b1;
      endcase
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (SIZE=8, CLK_FREQ=160, BAUD=10 -> 16 clk/bit).
// Build with UART_TX_PARITY_EN defined to exercise the parity variant.
module tb_uart_tx;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] word;
  logic       tx, busy, done;

  int n_pass;
  int n_checks;
  int hold_left;

  uart_tx #(.SIZE(8), .CLK_FREQ(160), .BAUD(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .word  (word),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for bit slot idx of a frame carrying w.
  function automatic logic exp_bit(input int w, input int idx);
    int ones;
    ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return ((w / (1 << (idx - 1))) % 2) == 1;
`ifdef UART_TX_PARITY_EN
    if (idx == 9) begin
      for (int i = 0; i < 8; i++) ones += (w / (1 << i)) % 2;
      return (ones % 2) == 1;
    end
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
  endtask

  // Advance to the next falling edge, releasing start when its hold expires.
  task automatic step();
    @(negedge clk);
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) start = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_tx", tx, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
    end
  endtask

  // One frame: optional fresh start pulse, 3-cycle acceptance latency, then
  // every cycle of the frame compared against the reference line pattern.
  task automatic frame(input logic [7:0] w, input int hold, input bit chained,
                       input int inject_at, input logic [7:0] inj_w,
                       input int abort_at, input bit chain_next,
                       input logic [7:0] next_w);
    if (!chained) begin
      word = w;
      start = 1'b1;
      hold_left = hold;
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("lat_tx w=%h k=%0d", w, k), tx, 1'b1);
      chk($sformatf("lat_done w=%h k=%0d", w, k), done, 1'b0);
      chk($sformatf("lat_busy w=%h k=%0d", w, k), busy, (k == 3));
    end
    for (int c = 0; c < FRAME; c++) begin
      step();
      if (c == inject_at) begin
        word = inj_w;
        start = 1'b1;
        hold_left = 1;
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        step();
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        rst_n = 1'b1;
        return;
      end
      chk($sformatf("tx w=%h c=%0d", w, c), tx, exp_bit(int'(w), c / DIV));
      chk($sformatf("busy w=%h c=%0d", w, c), busy, (c < FRAME - 1));
      chk($sformatf("done w=%h c=%0d", w, c), done, (c == FRAME - 1));
    end
    if (chain_next) begin
      word = next_w;
      start = 1'b1;
      hold_left = 1;
    end
  endtask

  initial begin
    n_pass = 0;
    n_checks = 0;
    hold_left = 0;
    rst_n = 1'b0;
    start = 1'b0;
    word = 8'h00;

    // Reset state.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
    end
    rst_n = 1'b1;
    idle(5);

    // Single frame of 8'h61.
    frame(8'h61, 1, 1'b0, -1, 8'h00, -1, 1'b0, 8'h00);
    idle(4);

`ifdef UART_TX_PARITY_EN
    // Parity-zero word.
    frame(8'h03, 1, 1'b0, -1, 8'h00, -1, 1'b0, 8'h00);
    idle(4);
`endif

    // Request while busy is dropped; word change mid-frame has no effect.
    frame(8'h61, 1, 1'b0, 50, 8'h62, -1, 1'b0, 8'h00);
    idle(20);

    // Back-to-back 8'h61..8'h7A, each started on the done cycle.
    frame(8'h61, 1, 1'b0, -1, 8'h00, -1, 1'b1, 8'h62);
    for (int i = 1; i < 26; i++) begin
      frame(8'(97 + i), 1, 1'b1, -1, 8'h00, -1, (i < 25), 8'(98 + i));
    end
    idle(10);

    // Reset mid-frame, then a clean frame.
    frame(8'h61, 1, 1'b0, -1, 8'h00, 70, 1'b0, 8'h00);
    idle(10);
    frame(8'h61, 1, 1'b0, -1, 8'h00, -1, 1'b0, 8'h00);
    idle(4);

    // Start held high for 1000 cycles yields exactly one frame.
    frame(8'h61, 1000, 1'b0, -1, 8'h00, -1, 1'b0, 8'h00);
    idle(1000 - 3 - FRAME + 20);

    // Randomized words, hold lengths and gaps.
    for (int i = 0; i < 8; i++) begin
      frame(8'($urandom_range(0, 255)), int'($urandom_range(1, 4)), 1'b0,
            -1, 8'h00, -1, 1'b0, 8'h00);
      idle(int'($urandom_range(0, 6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
